// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults and address-width helper for the multiport
//            register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int DATA_W_DEFAULT   = 64;
  localparam int ZERO_REG_DEFAULT = 31;

  // Index width for a register file of n entries; never narrower than 1 bit.
  function automatic int calc_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_mux.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rd_mux
// Purpose  : NUM_REGS:1 combinational read select for one read port. The
//            hardwired zero register always reads back as zero.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rd_mux
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int AW      = calc_aw(NUM_REGS)
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] data
);

  // A ZERO_REG outside the index range simply means no register is hardwired.
  localparam bit            HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < NUM_REGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(HAS_ZERO ? ZERO_REG : 0);

  // Select the addressed entry, forcing zero for the hardwired register.
  always_comb begin
    data = regs[addr];
    if (HAS_ZERO && (addr == ZERO_IDX)) begin
      data = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Purpose  : Single-write, NUM_RD-read register file with registered read
//            results (1-cycle latency) and a hardwired zero register.
//            Optional macro REGFILE_WR_BYPASS_EN forwards same-cycle write
//            data to matching read ports; without it, a read colliding with
//            a write returns the pre-write contents.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int AW      = calc_aw(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam bit            HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < NUM_REGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(HAS_ZERO ? ZERO_REG : 0);

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [DATA_W-1:0] sel_data [NUM_RD];
  logic              wr_to_zero;

  assign wr_to_zero = HAS_ZERO && (wr_addr == ZERO_IDX);

  // Storage array: cleared by reset, written on request except the zero register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && !wr_to_zero) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [DATA_W-1:0] mux_data;

    regfile_rd_mux #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_mux (
      .regs (regs),
      .addr (rd_addr[p*AW +: AW]),
      .data (mux_data)
    );

`ifdef REGFILE_WR_BYPASS_EN
    // Forward the in-flight write so the port sees the new value this cycle.
    assign sel_data[p] = (wr_en && !wr_to_zero && (wr_addr == rd_addr[p*AW +: AW]))
                         ? wr_data : mux_data;
`else
    assign sel_data[p] = mux_data;
`endif
  end

  // Read result registers: load on request, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_valid[p] <= rd_req[p];
        if (rd_req[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= sel_data[p];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Purpose  : Self-checking bench for regfile_multiport (NUM_RD = 4) against a
//            behavioural register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

  localparam int NR = 32;
  localparam int DW = 64;
  localparam int NP = 4;
  localparam int AW = 5;
  localparam int ZR = 31;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NP-1:0]    rd_req;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] mem      [NR];
  logic [DW-1:0] exp_data [NP];
  logic [NP-1:0] exp_valid;

  regfile_multiport #(
    .NUM_REGS (NR),
    .DATA_W   (DW),
    .NUM_RD   (NP),
    .ZERO_REG (ZR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mem[i] = '0;
    for (int p = 0; p < NP; p++) exp_data[p] = '0;
    exp_valid = '0;
  endtask

  task automatic set_all_addr(input logic [AW-1:0] a);
    for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = a;
  endtask

  // One rising edge: advance the model from the inputs present at the edge,
  // then settle 1 time unit before anything is sampled.
  task automatic tick();
    logic [AW-1:0] a;
    @(posedge clk);
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        a = rd_addr[p*AW +: AW];
        if (rd_req[p]) begin
          if (int'(a) == ZR)                         exp_data[p] = '0;
          else if (BYPASS && wr_en && wr_addr == a)  exp_data[p] = wr_data;
          else                                       exp_data[p] = mem[a];
          exp_valid[p] = 1'b1;
        end else begin
          exp_valid[p] = 1'b0;
        end
      end
      if (wr_en && int'(wr_addr) != ZR) mem[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;
    model_reset();
    #2;
    vectors++;
    if (rd_valid !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b data=%h required valid=0 data=0", rd_valid, rd_data);
    end
    #15 rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rd_req = '1;
      set_all_addr(AW'(i));
      tick();
      vectors++;
      if (rd_valid !== 4'b1111) begin
        miscompares++;
        $display("FAIL reset_read_valid X%0d: got %b required 1111", i, rd_valid);
      end
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (port_data(p) !== '0) begin
          miscompares++;
          $display("FAIL reset_read_data X%0d port%0d: got %h required 0", i, p, port_data(p));
        end
      end
    end
    rd_req = '0;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    wr_en = 1'b0; rd_req = 4'b0001; rd_addr[0 +: AW] = 5'd5;
    tick();
    rd_req = '0;
    vectors++;
    if (rd_valid !== 4'b0001 || port_data(0) !== 64'hDEAD_BEEF_0000_0001) begin
      miscompares++;
      $display("FAIL write_read_x5: got valid=%b data=%h required valid=0001 data=deadbeef00000001",
               rd_valid, port_data(0));
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
    tick();
    wr_en = 1'b0; rd_req = 4'b0010; rd_addr[AW +: AW] = 5'd31;
    tick();
    rd_req = '0;
    vectors++;
    if (rd_valid !== 4'b0010 || port_data(1) !== '0) begin
      miscompares++;
      $display("FAIL zero_reg_x31: got valid=%b data=%h required valid=0010 data=0",
               rd_valid, port_data(1));
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] want;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h10;
    tick();
    wr_data = 64'h20; rd_req = 4'b0001; rd_addr[0 +: AW] = 5'd7;
    tick();
    wr_en = 1'b0;
    want = BYPASS ? 64'h20 : 64'h10;
    vectors++;
    if (port_data(0) !== want) begin
      miscompares++;
      $display("FAIL same_cycle_x7: got %h required %h", port_data(0), want);
    end
    tick();
    rd_req = '0;
    vectors++;
    if (port_data(0) !== 64'h20) begin
      miscompares++;
      $display("FAIL after_write_x7: got %h required 20", port_data(0));
    end
  endtask

  task automatic test_partial_req();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h3;
    tick();
    wr_en = 1'b0; rd_req = 4'b1011; set_all_addr(5'd3);
    tick();
    rd_req = '0;
    vectors++;
    if (rd_valid !== 4'b1011) begin
      miscompares++;
      $display("FAIL partial_req_valid: got %b required 1011", rd_valid);
    end
    for (int p = 0; p < NP; p++) begin
      vectors++;
      if (p != 2 && port_data(p) !== 64'h3) begin
        miscompares++;
        $display("FAIL partial_req_data port%0d: got %h required 3", p, port_data(p));
      end else if (p == 2 && port_data(p) !== exp_data[2]) begin
        miscompares++;
        $display("FAIL partial_req_hold port2: got %h required %h", port_data(p), exp_data[2]);
      end
    end
  endtask

  task automatic test_idle();
    wr_en = 1'b0; rd_req = '0;
    repeat (3) tick();
    vectors++;
    if (rd_valid !== '0) begin
      miscompares++;
      $display("FAIL idle_valid: got %b required 0000", rd_valid);
    end
    for (int p = 0; p < NP; p++) begin
      vectors++;
      if (port_data(p) !== exp_data[p]) begin
        miscompares++;
        $display("FAIL idle_hold port%0d: got %h required %h", p, port_data(p), exp_data[p]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en   = 1'($urandom);
      wr_addr = AW'($urandom_range(0, NR - 1));
      wr_data = {$urandom, $urandom};
      rd_req  = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      end
      tick();
      vectors++;
      if (rd_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL random_valid cycle%0d: got %b required %b", n, rd_valid, exp_valid);
      end
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (port_data(p) !== exp_data[p]) begin
          miscompares++;
          $display("FAIL random_data cycle%0d port%0d: got %h required %h", n, p, port_data(p), exp_data[p]);
        end
      end
    end
    wr_en = 1'b0; rd_req = '0;
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
    tick();
    wr_en = 1'b0; rd_req = 4'b0001; rd_addr[0 +: AW] = 5'd9;
    tick();
    vectors++;
    if (rd_valid !== 4'b0001 || port_data(0) !== 64'h99) begin
      miscompares++;
      $display("FAIL pre_reset_x9: got valid=%b data=%h required valid=0001 data=99", rd_valid, port_data(0));
    end
    // Requests stay asserted across the reset; they must all be dropped.
    rd_req = '1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (rd_valid !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL async_reset_immediate: got valid=%b data=%h required 0", rd_valid, rd_data);
    end
    tick();
    vectors++;
    if (rd_valid !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_drops_req: got valid=%b data=%h required 0", rd_valid, rd_data);
    end
    #3 rst_n = 1'b1;
    wr_en = 1'b0; rd_req = 4'b0001; rd_addr[0 +: AW] = 5'd9;
    tick();
    rd_req = '0;
    vectors++;
    if (rd_valid !== 4'b0001 || port_data(0) !== '0) begin
      miscompares++;
      $display("FAIL post_reset_x9: got valid=%b data=%h required valid=0001 data=0", rd_valid, port_data(0));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_partial_req();
    test_idle();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of architectural registers; power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 64: register width in bits.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports, 1..8.
REQ-004 SHALL have parameter ZERO_REG, default 31: index hardwired to zero (XZR).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en, input, 1: write request this cycle.
REQ-008 SHALL have port wr_addr, input, AW = log2(NUM_REGS): write index.
REQ-009 SHALL have port wr_data, input, DATA_W: write value.
REQ-010 SHALL have port rd_req, input, NUM_RD: per-port read request.
REQ-011 SHALL have port rd_addr, input, NUM_RD x AW: per-port read index.
REQ-012 SHALL have port rd_data, output, NUM_RD x DATA_W: per-port registered read result.
REQ-013 SHALL have port rd_valid, output, NUM_RD: per-port qualifier for rd_data.

Function
REQ-014 SHALL store NUM_REGS x DATA_W bits; wr_en=1 writes wr_data to wr_addr at the rising clk edge.
REQ-015 SHALL ignore writes to ZERO_REG; reads of ZERO_REG always return 0.
REQ-016 SHALL give a read latency of exactly 1 cycle: rd_req[p]=1 at edge N loads rd_data[p] and sets rd_valid[p]=1 from edge N until edge N+1.
REQ-017 SHALL clear rd_valid[p] at the next edge when rd_req[p]=0; rd_data[p] holds its last value.
REQ-018 SHALL serve all NUM_RD ports independently in the same cycle, including several ports reading the same address.
REQ-019 SHALL, with bypass compiled out, return the pre-write contents when a read and a write hit the same address in the same cycle.
REQ-020 SHALL leave contents and outputs unchanged when wr_en=0 and rd_req=0.

Reset
REQ-021 SHALL, while rst_n=0, drive all registers, rd_data and rd_valid to 0 immediately, independent of clk.
REQ-022 SHALL drop a read requested in the same cycle rst_n asserts; rd_valid stays 0.
REQ-023 SHALL drop a write requested in the same cycle rst_n asserts.
REQ-024 SHALL accept requests at the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL use macro REGFILE_WR_BYPASS_EN to control same-cycle write-to-read forwarding.
REQ-026 SHALL, with REGFILE_WR_BYPASS_EN defined, return wr_data on any port whose rd_addr equals wr_addr while wr_en=1 and the address is not ZERO_REG.
REQ-027 SHALL, without REGFILE_WR_BYPASS_EN, behave per REQ-019 and instantiate no compare logic.

Structure
REQ-028 SHALL place the default constants (NUM_REGS, DATA_W, ZERO_REG) and the AW clog2 helper in the shared package regfile_pkg.
REQ-029 SHALL implement the per-port NUM_REGS:1 select as sub-module regfile_rd_mux, instantiated NUM_RD times.
REQ-030 SHALL keep read result registers and rd_valid in the top module.

Verification
REQ-031 SHALL cover: reset, then read all 32 registers on both ports -> rd_data=0 and rd_valid=1 one cycle after each request.
REQ-032 SHALL cover: write 0xDEAD_BEEF_0000_0001 to X5, then read X5 the next cycle -> that value one cycle later.
REQ-033 SHALL cover: write 0xFFFF_FFFF_FFFF_FFFF to X31, then read X31 -> 0.
REQ-034 SHALL cover: X7=0x10, then write 0x20 to X7 and read X7 in the same cycle -> 0x20 with bypass, 0x10 without.
REQ-035 SHALL cover: NUM_RD=4, all four ports read X3=0x3 with rd_req=4'b1011 -> rd_valid=4'b1011 and rd_data=0x3 on ports 0, 1 and 3.
REQ-036 SHALL cover: assert rst_n=0 mid-cycle while rd_valid=1 and X9=0x99 -> rd_valid=0 at once, and X9 reads 0 after release.
